// File: rtl/uart_phy.sv
// uart_phy: 8N1 UART bit engine. One fractional baud generator produces a 16x
// oversample tick that drives an independent serializer and deserializer.
module uart_phy (
   input  logic        CLK_I,
   input  logic        RESET_I,
   input  logic        RX_I,
   output logic        TX_O,
   input  logic [10:0] ADD_I,
   output logic [7:0]  RX_DATA_O,
   output logic        RX_VALID_O,
   output logic        RX_ERROR_O,
   output logic        TX_BUSY_O,
   input  logic [7:0]  TX_DATA_I,
   input  logic        TX_VALID_I
);

   // Handshakes: TX_VALID_I is a one-cycle strobe with no ready; it is taken
   // only while TX_BUSY_O is low, otherwise the byte is dropped. RX_VALID_O and
   // RX_ERROR_O are one-cycle pulses with no back-pressure; RX_DATA_O holds.

   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   localparam logic [2:0] RX_IDLE  = 3'd0;
   localparam logic [2:0] RX_START = 3'd1;
   localparam logic [2:0] RX_DATA  = 3'd2;
   localparam logic [2:0] RX_STOP  = 3'd3;
   localparam logic [2:0] RX_BREAK = 3'd4;

   // ---------------- baud generator ----------------
   logic [13:0] acc;
   logic [14:0] acc_sum;
   logic        tick;

   assign acc_sum = {1'b0, acc} + {4'b0000, ADD_I};

   always_ff @(posedge CLK_I or posedge RESET_I) begin
      if (RESET_I) begin
         acc  <= '0;
         tick <= 1'b0;
      end else begin
         acc  <= acc_sum[13:0];
         tick <= acc_sum[14];
      end
   end

   // ---------------- transmitter ----------------
   logic [1:0] tx_state;
   logic [3:0] tx_tick_cnt;
   logic [2:0] tx_bit_cnt;
   logic [7:0] tx_shift;
   logic       tx_bit_end;

   assign tx_bit_end = tick && (tx_tick_cnt == 4'd15);

   always_ff @(posedge CLK_I or posedge RESET_I) begin
      if (RESET_I) begin
         tx_state    <= TX_IDLE;
         tx_tick_cnt <= '0;
         tx_bit_cnt  <= '0;
         tx_shift    <= '0;
      end else begin
         // The 4-bit tick counter wraps to 0 exactly at each bit boundary.
         if ((tx_state != TX_IDLE) && tick)
            tx_tick_cnt <= tx_tick_cnt + 4'd1;
         case (tx_state)
            TX_IDLE: begin
               if (TX_VALID_I) begin
                  tx_shift    <= TX_DATA_I;
                  tx_tick_cnt <= '0;
                  tx_bit_cnt  <= '0;
                  tx_state    <= TX_START;
               end
            end
            TX_START: begin
               if (tx_bit_end)
                  tx_state <= TX_DATA;
            end
            TX_DATA: begin
               if (tx_bit_end) begin
                  tx_shift   <= {1'b0, tx_shift[7:1]};
                  tx_bit_cnt <= tx_bit_cnt + 3'd1;
                  if (tx_bit_cnt == 3'd7)
                     tx_state <= TX_STOP;
               end
            end
            default: begin
               if (tx_bit_end)
                  tx_state <= TX_IDLE;
            end
         endcase
      end
   end

   // Line level decoded from state so reset forces idle-high without a clock.
   always_comb begin
      TX_O = 1'b1;
      case (tx_state)
         TX_START: TX_O = 1'b0;
         TX_DATA:  TX_O = tx_shift[0];
         default:  TX_O = 1'b1;
      endcase
   end

   assign TX_BUSY_O = (tx_state != TX_IDLE);

   // ---------------- receiver ----------------
   logic       rx_meta;
   logic       rx_s;
   logic [2:0] rx_state;
   logic [3:0] rx_tick_cnt;
   logic [2:0] rx_bit_cnt;
   logic [7:0] rx_shift;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_error;
   logic       rx_half;
   logic       rx_full;

   always_ff @(posedge CLK_I or posedge RESET_I) begin
      if (RESET_I) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= RX_I;
         rx_s    <= rx_meta;
      end
   end

   assign rx_half = tick && (rx_tick_cnt == 4'd7);
   assign rx_full = tick && (rx_tick_cnt == 4'd15);

   always_ff @(posedge CLK_I or posedge RESET_I) begin
      if (RESET_I) begin
         rx_state    <= RX_IDLE;
         rx_tick_cnt <= '0;
         rx_bit_cnt  <= '0;
         rx_shift    <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         rx_error    <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         rx_error <= 1'b0;
         if (((rx_state == RX_START) || (rx_state == RX_DATA) || (rx_state == RX_STOP)) && tick)
            rx_tick_cnt <= rx_tick_cnt + 4'd1;
         case (rx_state)
            RX_IDLE: begin
               if (!rx_s) begin
                  rx_tick_cnt <= '0;
                  rx_state    <= RX_START;
               end
            end
            RX_START: begin
               // Half a bit into the start bit: re-centres sampling on bit middles.
               if (rx_half) begin
                  rx_tick_cnt <= '0;
                  rx_bit_cnt  <= '0;
                  rx_state    <= rx_s ? RX_IDLE : RX_DATA;
               end
            end
            RX_DATA: begin
               if (rx_full) begin
                  rx_shift   <= {rx_s, rx_shift[7:1]};
                  rx_bit_cnt <= rx_bit_cnt + 3'd1;
                  if (rx_bit_cnt == 3'd7)
                     rx_state <= RX_STOP;
               end
            end
            RX_STOP: begin
               if (rx_full) begin
                  if (rx_s) begin
                     rx_data  <= rx_shift;
                     rx_valid <= 1'b1;
                     rx_state <= RX_IDLE;
                  end else begin
                     rx_error <= 1'b1;
                     rx_state <= RX_BREAK;
                  end
               end
            end
            RX_BREAK: begin
               // A line held low reports one error, then waits for idle.
               if (rx_s)
                  rx_state <= RX_IDLE;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   assign RX_DATA_O  = rx_data;
   assign RX_VALID_O = rx_valid;
   assign RX_ERROR_O = rx_error;

endmodule

// File: tb/tb_uart_phy.sv
// tb_uart_phy: scenario tasks for uart_phy checked against a frame-level model
// (start 0, eight data bits LSB first, stop 1; bit = 16 * 2^14/ADD clocks).
module tb_uart_phy;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_in;
   logic        tx_o;
   logic [10:0] add;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_error;
   logic        tx_busy;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        loopback;
   logic        rx_drv;
   logic [7:0]  last_rx;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;

   logic [8:0]  ev_q[$];
   logic [8:0]  exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign rx_in = loopback ? tx_o : rx_drv;

   uart_phy dut (
      .CLK_I      (clk),
      .RESET_I    (rst),
      .RX_I       (rx_in),
      .TX_O       (tx_o),
      .ADD_I      (add),
      .RX_DATA_O  (rx_data),
      .RX_VALID_O (rx_valid),
      .RX_ERROR_O (rx_error),
      .TX_BUSY_O  (tx_busy),
      .TX_DATA_I  (tx_data),
      .TX_VALID_I (tx_valid)
   );

   // Receive monitor: each pulse logged as {error, data}.
   always @(negedge clk) begin
      if (rx_valid || rx_error)
         ev_q.push_back({rx_error, rx_data});
   end

   initial begin
      repeat (95000) @(posedge clk);
      $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   // ---------------- reference model ----------------
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0} >> k;
      return fr[0];
   endfunction

   // ---------------- drivers ----------------
   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_until(input int unsigned t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, output int unsigned s);
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      s        = cyc;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_tx_idle(input int budget, output logic ok);
      int n;
      n = 0;
      while (tx_busy === 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      ok = (tx_busy === 1'b0);
   endtask

   task automatic drive_rx_frame(input logic [7:0] b, input logic stop, input int bit_clks);
      for (int k = 0; k < 10; k++) begin
         rx_drv = (k == 9) ? stop : frame_bit(b, k);
         repeat (bit_clks) @(negedge clk);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int unsigned s;
      int bad;
      checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx_o: got %b want 1", tx_o); end
      checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
      checks++; if (rx_error !== 1'b0) begin errors++; $display("FAIL reset_rx_error: got %b want 0", rx_error); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
      add = 11'd1024;
      send_byte(8'hA5, s);
      wait_until(s + 600);
      checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b want 1", tx_busy); end
      #2 rst = 1'b1;
      #1;
      checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL async_rst_tx_o: got %b want 1", tx_o); end
      checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy: got %b want 0", tx_busy); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      ev_q.delete();
      bad = 0;
      repeat (2000) begin
         @(negedge clk);
         if (tx_o !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL post_rst_idle: got %0d bad cycles want 0", bad); end
      checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL post_rst_rx: got %0d events want 0", ev_q.size()); end
   endtask

   task automatic test_tx_timing();
      int unsigned s;
      int unsigned tt[$];
      logic        vq[$];
      logic        prev;
      int          n;
      loopback = 1'b0;
      rx_drv   = 1'b1;
      add      = 11'd1024;
      wait_cycles(20);
      send_byte(8'h55, s);
      checks++; if (tx_o !== 1'b0) begin errors++; $display("FAIL tx_start_latency: got %b want 0", tx_o); end
      checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL tx_busy_latency: got %b want 1", tx_busy); end
      tt.push_back(cyc);
      vq.push_back(tx_o);
      prev = tx_o;
      n = 0;
      while (tx_busy === 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
         if (cyc == s + 1000) begin
            tx_data  = 8'h00;
            tx_valid = 1'b1;
         end else begin
            tx_valid = 1'b0;
         end
         if (tx_busy === 1'b1 && tx_o !== prev) begin
            tt.push_back(cyc);
            vq.push_back(tx_o);
            prev = tx_o;
         end
      end
      tx_valid = 1'b0;
      checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL tx_busy_fall: got %b want 0", tx_busy); end
      checks++;
      if (tt.size() != 10) begin
         errors++; $display("FAIL tx_edges: got %0d edges want 10", tt.size());
      end else begin
         checks++;
         if (tt[1] - tt[0] < 241 || tt[1] - tt[0] > 256) begin
            errors++; $display("FAIL tx_start_len: got %0d want 241..256", tt[1] - tt[0]);
         end
         for (int j = 1; j < 9; j++) begin
            checks++;
            if (tt[j+1] - tt[j] != 256) begin
               errors++; $display("FAIL tx_bit_len[%0d]: got %0d want 256", j, tt[j+1] - tt[j]);
            end
         end
         checks++;
         if (cyc - tt[9] != 256) begin
            errors++; $display("FAIL tx_stop_len: got %0d want 256", cyc - tt[9]);
         end
         for (int j = 0; j < 10; j++) begin
            checks++;
            if (vq[j] !== frame_bit(8'h55, j)) begin
               errors++; $display("FAIL tx_bit_val[%0d]: got %b want %b", j, vq[j], frame_bit(8'h55, j));
            end
         end
      end
      n = 0;
      repeat (400) begin
         @(negedge clk);
         if (tx_busy !== 1'b0 || tx_o !== 1'b1) n++;
      end
      checks++; if (n != 0) begin errors++; $display("FAIL tx_drop_busy_strobe: got %0d active cycles want 0", n); end
   endtask

   task automatic test_tx_random();
      int unsigned s;
      int unsigned p;
      logic [7:0]  b;
      logic        ok;
      for (int f = 0; f < 3; f++) begin
         b   = 8'($urandom_range(0, 255));
         p   = ($urandom_range(0, 1) == 0) ? 32 : 16;
         add = 11'(16384 / p);
         send_byte(b, s);
         for (int k = 0; k < 10; k++) begin
            wait_until(s + 1 + 16 * p * k + 8 * p);
            checks++;
            if (tx_o !== frame_bit(b, k)) begin
               errors++; $display("FAIL tx_rand %h bit%0d: got %b want %b", b, k, tx_o, frame_bit(b, k));
            end
         end
         wait_tx_idle(32 * p, ok);
         checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tx_rand_idle: got busy %b want 0", tx_busy); end
      end
   endtask

   task automatic test_loopback();
      int unsigned s;
      logic [7:0]  b;
      logic        ok;
      loopback = 1'b1;
      add      = 11'd629;
      wait_cycles(10);
      for (int i = 0; i < 3; i++) begin
         b = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'hA5;
         ev_q.delete();
         send_byte(b, s);
         wait_tx_idle(6000, ok);
         wait_cycles(50);
         checks++; if (ok !== 1'b1) begin errors++; $display("FAIL loop_idle %h: got busy %b want 0", b, tx_busy); end
         checks++;
         if (ev_q.size() != 1) begin
            errors++; $display("FAIL loop_events %h: got %0d want 1", b, ev_q.size());
         end else if (ev_q[0] !== {1'b0, b}) begin
            errors++; $display("FAIL loop_byte: got %h want %h", ev_q[0], {1'b0, b});
         end
         checks++; if (rx_data !== b) begin errors++; $display("FAIL loop_hold: got %h want %h", rx_data, b); end
         last_rx = b;
      end
   endtask

   task automatic test_random_loopback();
      int unsigned s;
      logic [7:0]  b;
      logic        ok;
      loopback = 1'b1;
      ev_q.delete();
      exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         add = 11'($urandom_range(800, 2047));
         b   = 8'($urandom_range(0, 255));
         exp_q.push_back({1'b0, b});
         send_byte(b, s);
         wait_tx_idle(4000, ok);
         wait_cycles(40);
         checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rloop_idle add=%0d: got busy %b want 0", add, tx_busy); end
         last_rx = b;
      end
      checks++;
      if (ev_q.size() != exp_q.size()) begin
         errors++; $display("FAIL rloop_count: got %0d want %0d", ev_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (ev_q[i] !== exp_q[i]) begin
               errors++; $display("FAIL rloop_byte[%0d]: got %h want %h", i, ev_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_framing_error();
      loopback = 1'b0;
      rx_drv   = 1'b1;
      add      = 11'd1024;
      wait_cycles(20);
      ev_q.delete();
      drive_rx_frame(8'h3C, 1'b0, 256);
      rx_drv = 1'b0;
      wait_cycles(20 * 256);
      rx_drv = 1'b1;
      wait_cycles(512);
      checks++;
      if (ev_q.size() != 1) begin
         errors++; $display("FAIL frame_err_count: got %0d want 1", ev_q.size());
      end else if (ev_q[0] !== {1'b1, last_rx}) begin
         errors++; $display("FAIL frame_err_event: got %h want %h", ev_q[0], {1'b1, last_rx});
      end
      checks++; if (rx_data !== last_rx) begin errors++; $display("FAIL frame_err_hold: got %h want %h", rx_data, last_rx); end
      drive_rx_frame(8'h81, 1'b1, 256);
      wait_cycles(300);
      checks++;
      if (ev_q.size() != 2) begin
         errors++; $display("FAIL after_err_count: got %0d want 2", ev_q.size());
      end else if (ev_q[1] !== 9'h081) begin
         errors++; $display("FAIL after_err_byte: got %h want 081", ev_q[1]);
      end
      last_rx = 8'h81;
   endtask

   task automatic test_glitch();
      logic [7:0] g;
      loopback = 1'b0;
      rx_drv   = 1'b1;
      add      = 11'd1024;
      ev_q.delete();
      @(negedge clk);
      rx_drv = 1'b0;
      wait_cycles(48);
      rx_drv = 1'b1;
      wait_cycles(600);
      checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL glitch_events: got %0d want 0", ev_q.size()); end
      g = 8'($urandom_range(0, 255));
      drive_rx_frame(g, 1'b1, 256);
      wait_cycles(300);
      checks++;
      if (ev_q.size() != 1) begin
         errors++; $display("FAIL post_glitch_count: got %0d want 1", ev_q.size());
      end else if (ev_q[0] !== {1'b0, g}) begin
         errors++; $display("FAIL post_glitch_byte: got %h want %h", ev_q[0], {1'b0, g});
      end
      last_rx = g;
   endtask

   task automatic test_freeze();
      int unsigned s, f0, d;
      logic [7:0]  b;
      logic        v;
      logic        ok;
      int          bad;
      loopback = 1'b1;
      add      = 11'd1024;
      wait_cycles(10);
      ev_q.delete();
      b = 8'($urandom_range(0, 255));
      send_byte(b, s);
      f0 = s + 1 + 256 * 3 + 128;
      wait_until(f0);
      add = 11'd0;
      v   = tx_o;
      checks++; if (v !== frame_bit(b, 3)) begin errors++; $display("FAIL freeze_bit: got %b want %b", v, frame_bit(b, 3)); end
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (tx_o !== v || tx_busy !== 1'b1) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL freeze_hold: got %0d changed cycles want 0", bad); end
      checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL freeze_rx: got %0d events want 0", ev_q.size()); end
      d   = cyc - f0;
      add = 11'd1024;
      for (int k = 4; k < 10; k++) begin
         wait_until(s + 1 + 256 * k + 128 + d);
         checks++;
         if (tx_o !== frame_bit(b, k)) begin
            errors++; $display("FAIL thaw %h bit%0d: got %b want %b", b, k, tx_o, frame_bit(b, k));
         end
      end
      wait_tx_idle(600, ok);
      wait_cycles(50);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL thaw_idle: got busy %b want 0", tx_busy); end
      checks++;
      if (ev_q.size() != 1) begin
         errors++; $display("FAIL thaw_rx_count: got %0d want 1", ev_q.size());
      end else if (ev_q[0] !== {1'b0, b}) begin
         errors++; $display("FAIL thaw_rx_byte: got %h want %h", ev_q[0], {1'b0, b});
      end
      last_rx = b;
   endtask

   task automatic test_back_to_back();
      int unsigned s;
      logic [7:0]  a, b;
      logic        ok;
      loopback = 1'b1;
      add      = 11'd1024;
      wait_cycles(10);
      ev_q.delete();
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      send_byte(a, s);
      wait_tx_idle(3000, ok);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_first_idle: got busy %b want 0", tx_busy); end
      checks++; if (tx_busy !== 1'b1 || tx_o !== 1'b0) begin
         errors++; $display("FAIL b2b_accept: got busy %b line %b want 1 0", tx_busy, tx_o);
      end
      wait_tx_idle(3000, ok);
      wait_cycles(300);
      checks++;
      if (ev_q.size() != 2) begin
         errors++; $display("FAIL b2b_count: got %0d want 2", ev_q.size());
      end else if (ev_q[0] !== {1'b0, a} || ev_q[1] !== {1'b0, b}) begin
         errors++; $display("FAIL b2b_bytes: got %h %h want %h %h", ev_q[0], ev_q[1], {1'b0, a}, {1'b0, b});
      end
      last_rx = b;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      add      = 11'd0;
      loopback = 1'b0;
      rx_drv   = 1'b1;
      last_rx  = 8'h00;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_tx_timing();
      test_tx_random();
      test_loopback();
      test_random_loopback();
      test_framing_error();
      test_glitch();
      test_freeze();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_phy.md
# uart_phy

Bit-level UART engine: 8N1 serial transmitter and receiver sharing one fractional baud generator. Sits directly downstream of the AHB UART register wrapper: it serializes bytes handed over on the TX strobe, deserializes RX_I into byte/valid/error pulses, and takes its bit rate from the wrapper's 11-bit clock-increment register. It has no buffering beyond one byte per direction; the wrapper owns flags, interrupts and software-visible state.

## Interface
- No parameters; 8 data bits, no parity, 1 stop bit, 16x oversampling, 14-bit phase accumulator are fixed.
- CLK_I  in  1  system clock (48 MHz nominal)
- RESET_I  in  1  reset, asynchronous, active-high
- RX_I  in  1  serial input, asynchronous to CLK_I, idle high
- TX_O  out  1  serial output, idle high
- ADD_I  in  11  phase increment; oversample tick rate = f_CLK·ADD_I/2^14 (629 → 115200 baud at 48 MHz)
- RX_DATA_O  out  8  last received byte, held until next good frame
- RX_VALID_O  out  1  one-cycle pulse, good frame received
- RX_ERROR_O  out  1  one-cycle pulse, framing error (stop bit = 0)
- TX_BUSY_O  out  1  transmitter occupied
- TX_DATA_I  in  8  byte to send, sampled with TX_VALID_I
- TX_VALID_I  in  1  one-cycle send strobe

## Operation
- Reset values: TX_O=1, TX_BUSY_O=0, RX_VALID_O=0, RX_ERROR_O=0, RX_DATA_O=0; accumulator, counters 0; both FSMs IDLE; RX synchronizer flops = 1.
- Baud generator: acc <= acc + ADD_I mod 2^14; tick = carry out of that add, registered, one cycle wide. ADD_I=0 → no ticks, both FSMs freeze in place (no timeout). ADD_I changes apply from the next add; no realignment.
- TX FSM IDLE→START→DATA→STOP→IDLE; 16 ticks per bit; tick counter and bit counter cleared on capture.
  - IDLE: TX_VALID_I=1 latches TX_DATA_I, → START. TX_VALID_I while not IDLE ignored (byte dropped).
  - START: TX_O=0. DATA: TX_O = shift[0], LSB first, 8 bits. STOP: TX_O=1.
  - TX_BUSY_O=1 in START, DATA, STOP; falls when STOP's 16th tick returns FSM to IDLE.
- RX: RX_I through two flops (rx_s). FSM IDLE→START→DATA→STOP→(IDLE | BREAK).
  - IDLE: rx_s=0 → START, tick counter cleared.
  - START: on 8th tick sample rx_s; 1 → IDLE (glitch rejected), 0 → DATA.
  - DATA: sample every 16 ticks (bit centres), shift in LSB first, 8 samples → STOP.
  - STOP: sample at 16 ticks. 1 → RX_DATA_O <= byte, RX_VALID_O pulse, → IDLE. 0 → RX_ERROR_O pulse, RX_DATA_O unchanged, → BREAK.
  - BREAK: wait rx_s=1, → IDLE (a held-low line yields exactly one error).
- TX and RX fully independent; simultaneous activity allowed, loopback legal.

## Timing
- Tick period = 2^14/ADD_I clocks (exact when ADD_I divides 2^14); bit time = 16 ticks.
- TX: TX_VALID_I in cycle n → TX_BUSY_O=1 and TX_O=0 from cycle n+1. Start bit lasts until the 16th tick after capture, so first-bit length may shorten by up to one tick period; all later bits exactly 16 ticks.
- TX frame = 10 bit times; TX_BUSY_O low in the cycle after the final tick; a new TX_VALID_I in that cycle is accepted.
- RX: start-edge detection latency 2 clocks (synchronizer) + up to one tick; RX_VALID_O/RX_ERROR_O assert in the clock after the stop-bit sample tick; RX_DATA_O valid the same cycle and held.
- Async reset mid-frame: TX_O returns to 1 and all pulses drop combinationally with RESET_I; no partial byte reported after release.

## Test plan
- Reset: assert RESET_I mid-transmit of 0xA5 → TX_O=1, TX_BUSY_O=0 immediately; after release, idle line stays 1, no RX pulses.
- TX timing: ADD_I=1024 (tick every 16 clocks, bit = 256 clocks), send 0x55 → TX_O shows 0,1,0,1,0,1,0,1,0,1 each 256±16 clocks, TX_BUSY_O drops ~2560 clocks after strobe; second strobe while busy ignored.
- RX loopback: TX_O→RX_I, ADD_I=629, send 0x00, 0xFF, 0xA5 → one RX_VALID_O each with RX_DATA_O = sent byte, RX_ERROR_O never.
- Framing error: drive frame 0x3C with stop bit 0 then hold low 20 bit times → single RX_ERROR_O pulse, RX_DATA_O keeps previous byte; after line returns high, next good 0x81 yields RX_VALID_O.
- Glitch: 3-tick low pulse on RX_I (ADD_I=1024) → no VALID/ERROR, FSM back to IDLE.
- ADD_I=0 mid-frame → TX_O and TX_BUSY_O frozen; restoring ADD_I=1024 completes the frame with correct bits.
